// File: rtl/sdram_arbiter_if.sv
// sdram_arbiter_if: request/grant/done handshake bundle between the arbiter and its masters
interface sdram_arbiter_if;
  logic       init_done;
  logic       wr_trig;
  logic       rd_trig;
  logic       ref_done;
  logic       wr_done;
  logic       rd_done;
  logic       ref_en;
  logic       wr_en;
  logic       rd_en;
  logic [1:0] bus_sel;
  logic       busy;
  logic       ref_late;
  modport master (
    output init_done, wr_trig, rd_trig, ref_done, wr_done, rd_done,
    input  ref_en, wr_en, rd_en, bus_sel, busy, ref_late
  );
  modport slave (
    input  init_done, wr_trig, rd_trig, ref_done, wr_done, rd_done,
    output ref_en, wr_en, rd_en, bus_sel, busy, ref_late
  );
endinterface

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: fixed-priority (refresh > write > read) owner of the SDRAM command bus
module sdram_arbiter #(
  parameter int REF_PERIOD = 780,
  parameter int CNT_W      = 10
) (
  input logic            clk,
  input logic            rst,
  sdram_arbiter_if.slave sif
);
  typedef enum logic [2:0] {IDLE, ARBIT, REFRESH, WRITE, READ} state_t;
  state_t           state, nxt;
  logic [CNT_W-1:0] cnt;
  logic             ref_pend, wr_pend, rd_pend;
  logic             expire, g_ref, g_wr, g_rd;
  assign expire = sif.init_done && cnt == CNT_W'(REF_PERIOD - 1);
  assign g_ref  = state == ARBIT && nxt == REFRESH;
  assign g_wr   = state == ARBIT && nxt == WRITE;
  assign g_rd   = state == ARBIT && nxt == READ;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = ARBIT;
      ARBIT:   nxt = ref_pend ? REFRESH : wr_pend ? WRITE : rd_pend ? READ : ARBIT;
      REFRESH: nxt = sif.ref_done ? ARBIT : REFRESH;
      WRITE:   nxt = sif.wr_done ? ARBIT : WRITE;
      READ:    nxt = sif.rd_done ? ARBIT : READ;
      default: nxt = IDLE;
    endcase
    if (!sif.init_done) nxt = IDLE;
  end
  // losing init_done flushes every pending request and restarts the refresh timer
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      ref_pend     <= 1'b0;
      wr_pend      <= 1'b0;
      rd_pend      <= 1'b0;
      sif.ref_en   <= 1'b0;
      sif.wr_en    <= 1'b0;
      sif.rd_en    <= 1'b0;
      sif.bus_sel  <= 2'd0;
      sif.busy     <= 1'b0;
      sif.ref_late <= 1'b0;
    end else begin
      state        <= nxt;
      cnt          <= (!sif.init_done || expire) ? '0 : cnt + 1'b1;
      ref_pend     <= sif.init_done && (expire || (ref_pend && !g_ref));
      wr_pend      <= sif.init_done && (sif.wr_trig || (wr_pend && !g_wr));
      rd_pend      <= sif.init_done && (sif.rd_trig || (rd_pend && !g_rd));
      sif.ref_en   <= g_ref;
      sif.wr_en    <= g_wr;
      sif.rd_en    <= g_rd;
      sif.bus_sel  <= nxt == IDLE ? 2'd0 : nxt == REFRESH ? 2'd1 :
                      nxt == WRITE ? 2'd2 : nxt == READ ? 2'd3 : sif.bus_sel;
      sif.busy     <= nxt == REFRESH || nxt == WRITE || nxt == READ;
      sif.ref_late <= sif.ref_late || (expire && ref_pend);
    end
  end
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed checks of grant timing, priority, merging, late refresh and init drop
module tb_sdram_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  sdram_arbiter_if a ();
  sdram_arbiter_if b ();
  sdram_arbiter #(.REF_PERIOD(50), .CNT_W(6)) dut_a (.clk(clk), .rst(rst), .sif(a));
  sdram_arbiter #(.REF_PERIOD(20), .CNT_W(5)) dut_b (.clk(clk), .rst(rst), .sif(b));
  always #5 clk = ~clk;
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic quiet_a(input int n, input string tag);
    logic seen = 1'b0;
    repeat (n) begin
      tick(1);
      seen = seen | a.ref_en | a.wr_en | a.rd_en;
    end
    chk(tag, {7'd0, seen}, 8'd0);
  endtask
  initial begin
    {a.init_done, a.wr_trig, a.rd_trig, a.ref_done, a.wr_done, a.rd_done} = '0;
    {b.init_done, b.wr_trig, b.rd_trig, b.ref_done, b.wr_done, b.rd_done} = '0;
    tick(3);
    rst = 1'b0;
    chk("rst_en", {a.ref_en, a.wr_en, a.rd_en}, 0);
    chk("rst_sel", a.bus_sel, 0);
    chk("rst_busy_late", {a.busy, a.ref_late}, 0);
    // init: first refresh only after a full period
    a.init_done = 1'b1;
    tick(1);
    chk("init_busy", a.busy, 0);
    chk("init_sel", a.bus_sel, 0);
    chk("init_en", {a.ref_en, a.wr_en, a.rd_en}, 0);
    quiet_a(49, "init_quiet");
    tick(1);
    chk("ref1_en", a.ref_en, 1);
    chk("ref1_sel", a.bus_sel, 1);
    chk("ref1_busy", a.busy, 1);
    a.ref_done = 1'b1;
    tick(1);
    a.ref_done = 1'b0;
    chk("ref1_done", {a.busy, a.ref_en}, 0);
    chk("ref1_hold_sel", a.bus_sel, 1);
    // single write
    a.wr_trig = 1'b1;
    tick(1);
    a.wr_trig = 1'b0;
    chk("wr_lat", a.wr_en, 0);
    tick(1);
    chk("wr_en", a.wr_en, 1);
    chk("wr_sel", a.bus_sel, 2);
    chk("wr_busy", a.busy, 1);
    tick(1);
    chk("wr_pulse", {a.wr_en, a.busy}, 2'b01);
    tick(7);
    a.wr_done = 1'b1;
    tick(1);
    a.wr_done = 1'b0;
    chk("wr_done", a.busy, 0);
    chk("wr_hold_sel", a.bus_sel, 2);
    // priority: both triggers land on the expiry edge
    tick(36);
    a.wr_trig = 1'b1;
    a.rd_trig = 1'b1;
    tick(1);
    a.wr_trig = 1'b0;
    a.rd_trig = 1'b0;
    chk("pri_pend", {a.ref_en, a.wr_en, a.rd_en}, 0);
    tick(1);
    chk("pri_ref", {a.ref_en, a.wr_en, a.rd_en}, 3'b100);
    chk("pri_ref_sel", a.bus_sel, 1);
    tick(1);
    a.ref_done = 1'b1;
    tick(1);
    a.ref_done = 1'b0;
    chk("pri_gap1", {a.busy, a.wr_en}, 0);
    tick(1);
    chk("pri_wr", {a.ref_en, a.wr_en, a.rd_en}, 3'b010);
    chk("pri_wr_sel", a.bus_sel, 2);
    a.wr_done = 1'b1;
    tick(1);
    a.wr_done = 1'b0;
    chk("pri_gap2", {a.busy, a.rd_en}, 0);
    tick(1);
    chk("pri_rd", {a.ref_en, a.wr_en, a.rd_en}, 3'b001);
    chk("pri_rd_sel", a.bus_sel, 3);
    a.rd_done = 1'b1;
    tick(1);
    a.rd_done = 1'b0;
    chk("pri_rd_done", a.busy, 0);
    // merge: two rd_trig during a 30-cycle write
    a.wr_trig = 1'b1;
    tick(1);
    a.wr_trig = 1'b0;
    tick(1);
    chk("mrg_wr_en", a.wr_en, 1);
    tick(2);
    a.rd_trig = 1'b1;
    tick(1);
    a.rd_trig = 1'b0;
    tick(7);
    a.rd_trig = 1'b1;
    tick(1);
    a.rd_trig = 1'b0;
    tick(18);
    chk("mrg_hold", {a.rd_en, a.busy, a.bus_sel}, 4'b0110);
    a.wr_done = 1'b1;
    tick(1);
    a.wr_done = 1'b0;
    tick(1);
    chk("mrg_rd_en", a.rd_en, 1);
    chk("mrg_rd_sel", a.bus_sel, 3);
    tick(2);
    a.wr_done = 1'b1;
    tick(1);
    a.wr_done = 1'b0;
    chk("mrg_ign_wr_done", {a.busy, a.bus_sel}, 3'b111);
    tick(1);
    a.rd_done = 1'b1;
    tick(1);
    a.rd_done = 1'b0;
    chk("mrg_rd_done", a.busy, 0);
    quiet_a(5, "mrg_single_rd");
    tick(1);
    chk("ref2_en", a.ref_en, 1);
    a.ref_done = 1'b1;
    tick(1);
    a.ref_done = 1'b0;
    // init drop during read with a write pending
    a.rd_trig = 1'b1;
    tick(1);
    a.rd_trig = 1'b0;
    tick(1);
    chk("drop_rd_en", {a.rd_en, a.bus_sel}, 3'b111);
    a.wr_trig = 1'b1;
    tick(1);
    a.wr_trig = 1'b0;
    a.init_done = 1'b0;
    tick(1);
    chk("drop_idle", {a.busy, a.bus_sel}, 0);
    chk("drop_en", {a.ref_en, a.wr_en, a.rd_en}, 0);
    a.init_done = 1'b1;
    a.rd_done = 1'b1;
    tick(1);
    a.rd_done = 1'b0;
    chk("drop_rd_done_ign", {a.busy, a.bus_sel, a.ref_en, a.wr_en, a.rd_en}, 0);
    quiet_a(49, "drop_quiet");
    tick(1);
    chk("drop_ref_en", {a.ref_en, a.bus_sel}, 3'b101);
    chk("a_no_late", a.ref_late, 0);
    a.ref_done = 1'b1;
    tick(1);
    a.ref_done = 1'b0;
    a.init_done = 1'b0;
    // late refresh on the short-period instance
    b.init_done = 1'b1;
    b.wr_trig = 1'b1;
    tick(1);
    b.wr_trig = 1'b0;
    tick(1);
    chk("late_wr_en", {b.wr_en, b.bus_sel}, 3'b110);
    tick(37);
    chk("late_first", b.ref_late, 0);
    tick(1);
    chk("late_second", b.ref_late, 1);
    tick(6);
    b.wr_done = 1'b1;
    tick(1);
    b.wr_done = 1'b0;
    chk("late_after_wr", {b.busy, b.ref_late}, 2'b01);
    tick(1);
    chk("late_ref_en", {b.ref_en, b.bus_sel}, 3'b101);
    b.ref_done = 1'b1;
    tick(1);
    b.ref_done = 1'b0;
    chk("late_after_ref", {b.busy, b.ref_late}, 2'b01);
    tick(5);
    chk("late_sticky", b.ref_late, 1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("late_rst", {b.ref_late, b.busy, b.bus_sel}, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Sequences access to the single SDRAM command bus among three masters: auto-refresh, write burst, and read burst. It sits between the UART command decoder, which supplies `wr_trig`/`rd_trig` pulses, and the SDRAM refresh, write and read sub-modules. It holds single-deep pending requests, generates the periodic refresh request internally, and grants one master at a time with a start-pulse/done handshake. Fixed priority is refresh > write > read.

## Interface
- `REF_PERIOD`, default 780: clock cycles between refresh requests (7.8 us at 100 MHz).
- `CNT_W`, default 10: width of the refresh counter; must satisfy 2^CNT_W >= REF_PERIOD.

- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `init_done` in 1: SDRAM power-up init complete; level.
- `wr_trig` in 1: one-cycle write request from the command decoder.
- `rd_trig` in 1: one-cycle read request from the command decoder.
- `ref_done` in 1: refresh sub-module finished; one-cycle pulse.
- `wr_done` in 1: write sub-module finished; one-cycle pulse.
- `rd_done` in 1: read sub-module finished; one-cycle pulse.
- `ref_en` out 1: one-cycle start pulse to the refresh sub-module.
- `wr_en` out 1: one-cycle start pulse to the write sub-module.
- `rd_en` out 1: one-cycle start pulse to the read sub-module.
- `bus_sel` out 2: SDRAM bus mux select. 0 = init, 1 = refresh, 2 = write, 3 = read.
- `busy` out 1: high in REFRESH, WRITE or READ.
- `ref_late` out 1: sticky error; a refresh period expired while the previous refresh was still pending.

## Operation
- States: IDLE, ARBIT, REFRESH, WRITE, READ. Reset state is IDLE.
- IDLE: `bus_sel`=0. Moves to ARBIT on the first cycle `init_done`=1.
- ARBIT: `bus_sel` holds its last value. Grant rules, evaluated on the registered pending flags:
  - `ref_pend` -> REFRESH
  - else `wr_pend` -> WRITE
  - else `rd_pend` -> READ
  - else stay in ARBIT.
- Granting a master:
  - The transition edge sets the matching `*_en`=1 for exactly one cycle.
  - `bus_sel` updates on the same edge.
  - The matching pending flag clears on the same edge.
- REFRESH, WRITE, READ: the state holds until the matching `*_done` is sampled high, then returns to ARBIT.
  - `*_done` is honoured in any cycle of the state, including the `*_en` cycle.
  - `*_done` inputs that do not match the current state are ignored.
- No preemption. `REF_PERIOD` budgets for the worst-case burst.
- At least one ARBIT cycle separates two consecutive grants.
- Pending flags (`wr_pend`, `rd_pend`, `ref_pend`):
  - Set by `wr_trig`/`rd_trig`/counter expiry.
  - Cleared on grant.
  - A set and a clear in the same cycle leave the flag at 1.
  - A trigger arriving while its flag is already 1 is merged (lost). Only `ref_late` flags this case, and only for refresh.
- Refresh counter:
  - Counts 0..REF_PERIOD-1 while `init_done`=1; held at 0 otherwise.
  - At REF_PERIOD-1 it wraps to 0 and sets `ref_pend`.
  - If `ref_pend` is already 1 at expiry, `ref_late` sets and stays set until `rst`.
- `init_done` falling in any state:
  - Next state is IDLE.
  - All pending flags and the counter clear.
  - `*_en` outputs are 0.
  - An in-flight `*_done` is ignored.
- Reset values: all outputs 0, state IDLE, counter 0, all pending flags 0.

## Timing
- Triggers are sampled at edge T, so `*_pend`=1 after T.
- If the arbiter is idle in ARBIT, `*_en` is high in the cycle after edge T+1 (two-edge latency).
- `*_done` sampled at edge D: state is ARBIT after D. The next grant is taken at edge D+1, so `*_en` is high after D+1.
- `busy` and `bus_sel` are registered and change on the same edge as the state.
- Counter expiry at edge E: `ref_pend` is set after E. If in ARBIT, `ref_en` is high after E+1.
- Simultaneous `wr_trig` and `rd_trig` in ARBIT: write is granted first. Read is granted one ARBIT cycle after `wr_done`.
- `rst` overrides everything on the edge it is sampled.

## Test plan
- Reset and init:
  - Hold `rst` for 3 cycles.
  - Required: all outputs 0, `bus_sel`=0.
  - Raise `init_done`: ARBIT one edge later; no `*_en` for REF_PERIOD-1 cycles.
- Single write:
  - `REF_PERIOD`=50. Pulse `wr_trig` at cycle 10.
  - Required: `wr_en` one cycle wide at cycle 12; `bus_sel`=2; `busy`=1.
  - Pulse `wr_done` at cycle 20: `busy`=0 at cycle 21.
- Priority:
  - Pulse `wr_trig` and `rd_trig` in the same cycle, timed so the refresh counter expires on the same edge.
  - Required grant order: `ref_en`, then `wr_en`, then `rd_en`, each separated by its done plus one ARBIT cycle.
- Merge and hold:
  - During a 30-cycle WRITE, pulse `rd_trig` twice.
  - Required: exactly one `rd_en`, issued after `wr_done`.
  - Pulse `wr_done` while in READ: ignored; state stays READ.
- Late refresh:
  - `REF_PERIOD`=20. Hold WRITE 45 cycles without `wr_done`.
  - Required: `ref_late`=1 at the second expiry; it stays 1 after `wr_done` and after refresh completes, until `rst`.
- Init drop:
  - In READ, drop `init_done` for 1 cycle.
  - Required: IDLE next edge, `bus_sel`=0, pending flags cleared.
  - `rd_done` arriving in IDLE is ignored.
  - After `init_done` returns, no grant until a new trigger or a full `REF_PERIOD`.
